// File: rtl/conv_window_gen.sv
// Sliding FNxFN window generator over a raster pixel stream, CH channels in parallel.
// Define CONV_WINDOW_STRIDE2_EN to emit only windows at even row/column offsets (stride 2).
module conv_window_gen #(
  parameter int WIDTH = 16,
  parameter int CH    = 1,
  parameter int FN    = 3,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH*WIDTH-1:0]          in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH*FN*FN*WIDTH-1:0]    out_win,
  output logic                         out_last,
  output logic                         dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST    = CW'(FN - 1);
  localparam logic [RW-1:0] ROW_FILL_END = RW'(FN - 2);
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam logic [RW-1:0] ROW_FIRST = RW'(FN - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1 - ((IMG_W - FN) % 2));
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1 - ((IMG_H - FN) % 2));
`else
  localparam logic [CW-1:0] COL_LAST  = COL_MAX;
  localparam logic [RW-1:0] ROW_LAST  = ROW_MAX;
`endif

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          emit;
  logic          is_last;

  // line_buf[c][0] holds the oldest buffered row, line_buf[c][FN-2] the row just above.
  logic [WIDTH-1:0] line_buf [CH][FN-1][IMG_W];
  logic [WIDTH-1:0] win_q    [CH][FN][FN];
  logic [CH*FN*FN*WIDTH-1:0] win_next;

  // Handshake: a beat moves when valid && ready on the same rising edge; the single
  // output register frees up as it is consumed, so input may be taken in that cycle.
  assign in_ready  = !resetn && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    emit = accept && (state == RUN) && (col >= COL_FIRST);
`ifdef CONV_WINDOW_STRIDE2_EN
    emit = emit && (col[0] == COL_FIRST[0]) && (row[0] == ROW_FIRST[0]);
`endif
    is_last = (row == ROW_LAST) && (col == COL_LAST);
  end

  // Window after this beat: every row shifts left, new right column comes from buffers + input.
  always_comb begin
    win_next = '0;
    for (int c = 0; c < CH; c++) begin
      for (int j = 0; j < FN; j++) begin
        for (int i = 0; i < FN - 1; i++) begin
          win_next[((c*FN+j)*FN+i)*WIDTH +: WIDTH] = win_q[c][j][i+1];
        end
      end
      for (int j = 0; j < FN - 1; j++) begin
        win_next[((c*FN+j)*FN+FN-1)*WIDTH +: WIDTH] = line_buf[c][j][col];
      end
      win_next[((c*FN+FN-1)*FN+FN-1)*WIDTH +: WIDTH] = in_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < FN - 2; k++) begin
          line_buf[c][k][col] <= line_buf[c][k+1][col];
        end
        line_buf[c][FN-2][col] <= in_data[c*WIDTH +: WIDTH];
        for (int j = 0; j < FN; j++) begin
          for (int i = 0; i < FN; i++) begin
            win_q[c][j][i] <= win_next[((c*FN+j)*FN+i)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      col       <= '0;
      row       <= '0;
      state     <= FILL;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_win   <= '0;
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (row == ROW_MAX) begin
          row   <= '0;
          state <= FILL;
        end else begin
          row <= row + 1'b1;
          if (row == ROW_FILL_END) state <= RUN;
        end
      end else begin
        col <= col + 1'b1;
      end
      out_valid <= emit;
      if (emit) begin
        out_win  <= win_next;
        out_last <= is_last;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: 5x5 frames, two channels, scoreboard fed by an image-array model.
module tb_conv_window_gen;

  localparam int WIDTH = 16;
  localparam int CH    = 2;
  localparam int FN    = 3;
  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int OW    = CH*FN*FN*WIDTH;
  localparam int XW    = OW + 1;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int WPF    = 4;
  localparam int HOLD_P = 14;
  localparam int LAST_R = IMG_H - 1 - ((IMG_H - FN) % 2);
  localparam int LAST_C = IMG_W - 1 - ((IMG_W - FN) % 2);
`else
  localparam int WPF    = 9;
  localparam int HOLD_P = 18;
  localparam int LAST_R = IMG_H - 1;
  localparam int LAST_C = IMG_W - 1;
`endif

  typedef logic [XW-1:0] xw_t;

  logic                clk;
  logic                resetn;
  logic                in_valid;
  logic                in_ready;
  logic [CH*WIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_win;
  logic                out_last;
  logic                dbg_state;

  logic force_rdy;
  logic rnd_rdy;
  logic rand_phase;
  logic mon_en;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   win_cnt = 0;
  int   last_cnt = 0;
  int   mr = 0;
  int   mc = 0;
  logic [WIDTH-1:0] img [CH][IMG_H][IMG_W];
  xw_t  exp_q[$];

  assign out_ready = rand_phase ? rnd_rdy : force_rdy;

  conv_window_gen #(
    .WIDTH(WIDTH), .CH(CH), .FN(FN), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string tag, input xw_t obs, input xw_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Window of a directed frame whose top-left pixel is (r0,c0); channel c adds 50*c.
  function automatic logic [OW-1:0] pack_win(input int r0, input int c0, input int off);
    logic [OW-1:0] w;
    w = '0;
    for (int c = 0; c < CH; c++)
      for (int j = 0; j < FN; j++)
        for (int i = 0; i < FN; i++)
          w[((c*FN+j)*FN+i)*WIDTH +: WIDTH] = WIDTH'((r0+j)*IMG_W + (c0+i) + off + 50*c);
    return w;
  endfunction

  function automatic bit emits(input int r, input int c);
    if (r < FN-1 || c < FN-1) return 1'b0;
`ifdef CONV_WINDOW_STRIDE2_EN
    return ((r-(FN-1)) % 2 == 0) && ((c-(FN-1)) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_accept();
    logic [OW-1:0] w;
    for (int c = 0; c < CH; c++) img[c][mr][mc] = in_data[c*WIDTH +: WIDTH];
    if (emits(mr, mc)) begin
      w = '0;
      for (int c = 0; c < CH; c++)
        for (int j = 0; j < FN; j++)
          for (int i = 0; i < FN; i++)
            w[((c*FN+j)*FN+i)*WIDTH +: WIDTH] = img[c][mr-FN+1+j][mc-FN+1+i];
      exp_q.push_back({(mr == LAST_R && mc == LAST_C), w});
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr = (mr == IMG_H-1) ? 0 : mr + 1;
    end
  endtask

  // scoreboard monitor, mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", xw_t'(out_valid), xw_t'(exp_q.size() != 0));
      chk("in_ready", xw_t'(in_ready), xw_t'(!resetn && (!out_valid || out_ready)));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_win", xw_t'(out_win), xw_t'(exp_q[0][OW-1:0]));
        chk("out_last", xw_t'(out_last), xw_t'(exp_q[0][OW]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          win_cnt++;
          if (out_last) last_cnt++;
        end
      end
      if (resetn) begin
        exp_q.delete();
        mr = 0;
        mc = 0;
      end else if (in_valid && in_ready) begin
        model_accept();
      end
    end
  end

  // driver tasks: entered and left just after a rising edge
  task automatic send_pixel(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1, input int gap);
    int guard;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = {v1, v0};
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        total++;
        bad++;
        $error("FAIL send_timeout: observed=no accept expected=accept within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input int off);
    for (int p = from; p <= to; p++) send_pixel(WIDTH'(p + off), WIDTH'(p + off + 50), 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk); #1;
    chk("drain", xw_t'(exp_q.size()), xw_t'(0));
  endtask

  initial begin
    int w0;
    int t0;
    resetn     = 1'b1;
    in_valid   = 1'b1;
    in_data    = '1;
    force_rdy  = 1'b1;
    rand_phase = 1'b0;
    mon_en     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", xw_t'(out_valid), xw_t'(0));
    chk("rst_out_last", xw_t'(out_last), xw_t'(0));
    chk("rst_out_win", xw_t'(out_win), xw_t'(0));
    chk("rst_in_ready", xw_t'(in_ready), xw_t'(0));
    @(posedge clk); #1;
    resetn   = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // frame A: continuous stream, first and last window checked directly
    send_range(0, 12, 0);
    @(negedge clk);
    chk("a_first_valid", xw_t'(out_valid), xw_t'(1));
    chk("a_first_win", xw_t'(out_win), xw_t'(pack_win(0, 0, 0)));
    chk("a_first_last", xw_t'(out_last), xw_t'(0));
    @(posedge clk); #1;
    send_range(13, 24, 0);
    @(negedge clk);
    chk("a_final_valid", xw_t'(out_valid), xw_t'(1));
    chk("a_final_win", xw_t'(out_win), xw_t'(pack_win(LAST_R-2, LAST_C-2, 0)));
    chk("a_final_last", xw_t'(out_last), xw_t'(1));
    @(posedge clk); #1;
    drain();
    chk("a_count", xw_t'(win_cnt), xw_t'(WPF));
    chk("a_last_count", xw_t'(last_cnt), xw_t'(1));

    // frame B: three cycles of backpressure on a held window
    w0 = win_cnt;
    send_range(0, HOLD_P, 0);
    force_rdy = 1'b0;
    in_valid  = 1'b1;
    in_data   = {WIDTH'(HOLD_P + 51), WIDTH'(HOLD_P + 1)};
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", xw_t'(out_valid), xw_t'(1));
      chk("bp_win", xw_t'(out_win), xw_t'(pack_win(HOLD_P/IMG_W - 2, HOLD_P%IMG_W - 2, 0)));
      chk("bp_in_ready", xw_t'(in_ready), xw_t'(0));
    end
    @(posedge clk); #1;
    force_rdy = 1'b1;
    send_range(HOLD_P + 1, 24, 0);
    drain();
    chk("b_count", xw_t'(win_cnt - w0), xw_t'(WPF));

    // frames C and D back to back, D offset by 100
    w0 = win_cnt;
    t0 = cyc;
    send_range(0, 24, 0);
    send_range(0, 12, 100);
    chk("cd_throughput", xw_t'(cyc - t0), xw_t'(38));
    @(negedge clk);
    chk("d_first_win", xw_t'(out_win), xw_t'(pack_win(0, 0, 100)));
    @(posedge clk); #1;
    send_range(13, 24, 100);
    drain();
    chk("cd_count", xw_t'(win_cnt - w0), xw_t'(2*WPF));

    // reset one cycle after pixel 17 with the output stalled, then a fresh frame
    send_range(0, 17, 0);
    force_rdy = 1'b0;
    resetn    = 1'b1;
    @(posedge clk); #1;
    resetn    = 1'b0;
    force_rdy = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", xw_t'(out_valid), xw_t'(0));
    @(posedge clk); #1;
    w0 = win_cnt;
    send_range(0, 24, 0);
    drain();
    chk("f_count", xw_t'(win_cnt - w0), xw_t'(WPF));

    // random data, random input gaps, random downstream stalls
    rand_phase = 1'b1;
    for (int f = 0; f < 3; f++) begin
      w0 = win_cnt;
      for (int p = 0; p < IMG_W*IMG_H; p++)
        send_pixel(WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
      drain();
      chk("rand_count", xw_t'(win_cnt - w0), xw_t'(WPF));
    end
    rand_phase = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_queue_empty", xw_t'(exp_q.size()), xw_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
